// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the parametrised UART receiver:
//               parity mode constants, receive FSM state encoding, baud tick
//               divider calculation and FIFO entry width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity modes selected by the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Receive FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_freq + den / 2) / den);
    endfunction

    // FIFO entry carries {ferr, perr, data}
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Small synchronous FIFO with full/empty flags. Push and pop may
//               occur in the same cycle; a push into a full FIFO is accepted
//               only when a pop frees a slot in that cycle. The head entry is
//               read directly from storage (no bypass from push to head).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write request and data
//               pop             - read request (ignored when empty)
//               head            - entry at the FIFO head
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head reads zero until first write.
    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver. 3-sample majority
//               vote per bit, optional odd/even parity, 1 or 2 stop bits,
//               framing/parity error flags, break detection, and an output
//               FIFO presented as a valid/ready stream.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               rx            - asynchronous serial input, idle high
//               m_data        - payload at FIFO head
//               m_perr/m_ferr - parity / framing error of head entry
//               m_valid       - head entry available
//               m_ready       - consumer accepts head entry
//               overrun       - sticky, frame dropped on full FIFO
//               overrun_clr   - clears overrun (set wins)
//               break_det     - one-cycle pulse on break detection
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 break_det
);

    localparam int DIV      = calc_div(longint'(CLK_FREQ), longint'(BAUD),
                                       longint'(OVERSAMPLE));
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int BIT_CLKS = DIV * OVERSAMPLE;
    localparam int HI_W     = $clog2(BIT_CLKS + 1);
    localparam int BCNT_W   = $clog2(DATA_BITS);
    localparam int ENTRY_W  = entry_width(DATA_BITS);

    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]   C_OS_LAST  = OS_W'(OVERSAMPLE - 1);
    // Counter value at the tick that is the Nth tick since the bit start
    // is N-1, so these select ticks OS/2-1, OS/2 and OS/2+1.
    localparam logic [OS_W-1:0]   C_SMP0     = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0]   C_SMP1     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   C_SMP2     = OS_W'(OVERSAMPLE / 2);
    localparam logic [HI_W-1:0]   C_HI_LAST  = HI_W'(BIT_CLKS - 1);
    localparam logic [BCNT_W-1:0] C_BIT_LAST = BCNT_W'(DATA_BITS - 1);
    localparam logic              C_STOP_LAST = (STOP_BITS == 2);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect (all idle-high on reset)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    rx_state_t            r_state;
    logic                 r_armed;
    logic [HI_W-1:0]      r_high_cnt;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_data;
    logic [BCNT_W-1:0]    r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_par_zero;
    logic                 r_break_det;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_decide;
    logic                 w_maj;
    logic                 w_par_exp;
    logic                 w_break;
    logic                 w_push;
    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

    assign w_tick   = (r_div_cnt == C_DIV_LAST);
    // Bit decision happens on the third sample tick, using the two stored
    // samples plus the live synchronised line value.
    assign w_decide = w_tick && (r_os_cnt == C_SMP2);
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    // Expected parity bit: even mode makes the total count of ones even
    assign w_par_exp = (PARITY == PAR_ODD) ? ~^r_data : ^r_data;

    // Break is judged on the first stop bit: all-zero payload, zero parity
    // bit (or no parity) and a low stop sample.
    assign w_break  = (r_stop_cnt == 1'b0) && (r_data == '0) && r_par_zero && !w_maj;

    assign w_push   = (r_state == ST_STOP) && w_decide && !w_break
                      && (r_stop_cnt == C_STOP_LAST);
    assign w_entry  = {r_ferr | ~w_maj, r_perr, r_data};
    assign w_pop    = !w_empty && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_high_cnt  <= '0;
            r_div_cnt   <= '0;
            r_os_cnt    <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_data      <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_par_zero  <= 1'b1;
            r_break_det <= 1'b0;
        end else begin
            r_break_det <= 1'b0;

            // Free-running tick/oversample counters; realigned on start edge
            if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= (r_os_cnt == C_OS_LAST) ? '0 : r_os_cnt + 1'b1;
                if (r_os_cnt == C_SMP0) r_s0 <= w_rx;
                if (r_os_cnt == C_SMP1) r_s1 <= w_rx;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_armed) begin
                        // Require one full bit time of idle line first
                        if (!w_rx) begin
                            r_high_cnt <= '0;
                        end else if (r_high_cnt == C_HI_LAST) begin
                            r_armed    <= 1'b1;
                            r_high_cnt <= '0;
                        end else begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end else if (w_fall) begin
                        r_state    <= ST_START;
                        r_div_cnt  <= '0;
                        r_os_cnt   <= '0;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_par_zero <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_decide) begin
                        r_state <= w_maj ? ST_IDLE : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        r_data <= {w_maj, r_data[DATA_BITS-1:1]};
                        if (r_bit_cnt == C_BIT_LAST) begin
                            r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_decide) begin
                        r_perr     <= (w_maj != w_par_exp);
                        r_par_zero <= ~w_maj;
                        r_state    <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_decide) begin
                        if (w_break) begin
                            r_state     <= ST_BREAK;
                            r_break_det <= 1'b1;
                            r_high_cnt  <= '0;
                        end else if (r_stop_cnt == C_STOP_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr     <= r_ferr | ~w_maj;
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end

                ST_BREAK: begin
                    if (!w_rx) begin
                        r_high_cnt <= '0;
                    end else if (r_high_cnt == C_HI_LAST) begin
                        r_state    <= ST_IDLE;
                        r_high_cnt <= '0;
                    end else begin
                        r_high_cnt <= r_high_cnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overrun: a push into a full FIFO that is not popping drops the
    // frame. Setting takes priority over clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign m_data    = w_head[DATA_BITS-1:0];
    assign m_perr    = w_head[DATA_BITS];
    assign m_ferr    = w_head[DATA_BITS+1];
    assign m_valid   = ~w_empty;
    assign overrun   = r_overrun;
    assign break_det = r_break_det;

endmodule
`default_nettype wire
